bpt_update_ctrl: RTL and testbench
==================================

# bpt_update_ctrl

Write-port controller for the branch prediction table. It buffers branch-resolution updates from the ID stage and performs a read-modify-write of each entry's 2-bit saturating counter, valid bit and target. It also owns the initialization sweep after reset or on request, and is the only writer of the table. The IF-stage read port stays outside this block; `busy` tells the fetch logic to suppress predictions while a sweep runs.

## Interface
- `N_REG`, 16: table entries (power of two).
- `N_BITS`, $clog2(N_REG): index width.
- `QDEPTH`, 4: update queue depth (power of two, ≥2).
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `upd_valid` in 1: resolved branch update offered.
- `upd_ready` out 1: queue can accept; equals !full.
- `upd_idx` in N_BITS: table index of the resolved branch.
- `upd_target` in 64: computed branch PC.
- `upd_mispredict` in 1: 1 means the prediction was wrong (pipeline flushed).
- `sweep_req` in 1: single-cycle request to reinitialize the whole table.
- `tbl_rd_idx` out N_BITS: counter read index.
- `tbl_rd_ctr` in 2: counter at `tbl_rd_idx`, combinational from the table.
- `tbl_we` out 1: table write strobe.
- `tbl_wr_idx` out N_BITS, `tbl_wr_target` out 64, `tbl_wr_ctr` out 2, `tbl_wr_valid` out 1: write data.
- `busy` out 1: sweep in progress.

## Operation
- Update flow:
  - A handshake completes on `upd_valid & upd_ready` at a rising edge. `{idx, target, mispredict}` is pushed into a FIFO.
  - The FSM pops entries in order, one read-modify-write per entry.
- FSM states and transitions:
  - SWEEP → IDLE after entry N_REG-1 is written.
  - IDLE → READ when the queue is non-empty.
  - READ → WRITE unconditionally.
  - WRITE → READ if the queue is still non-empty after the pop; otherwise WRITE → IDLE.
  - `sweep_req` → SWEEP from any state, with the sweep index reset to 0. This also applies when already in SWEEP (the sweep restarts).
- SWEEP:
  - One entry per cycle, index 0..N_REG-1.
  - Writes ctr=01, valid=0, target=0.
  - `busy`=1.
- READ:
  - `tbl_rd_idx` = head idx.
  - `tbl_rd_ctr` is registered into `ctr_q`.
- WRITE:
  - `tbl_we`=1, `tbl_wr_idx` = head idx, `tbl_wr_target` = head target, `tbl_wr_valid`=1, `tbl_wr_ctr` = next(ctr_q).
  - The FIFO pops at the end of this cycle.
- Counter update, when correct (`mispredict`=0): 00→00, 01→00, 10→11, 11→11.
- Counter update, when mispredicted: 00→01, 01→10, 10→01, 11→10.
- When `tbl_we`=0, all `tbl_wr_*` outputs are 0. When not in READ, `tbl_rd_idx`=0.
- The queue accepts pushes in every state, including SWEEP.
- Boundary cases:
  - Full queue: `upd_ready`=0. No push, even in a pop cycle.
  - FIFO pointers wrap modulo QDEPTH. Count is held in N_BITS-independent $clog2(QDEPTH)+1 bits.
  - `sweep_req` in WRITE: that cycle's write still commits. The FIFO is then cleared, so the popped entry is not replayed.
  - `sweep_req` in READ: the read is abandoned.
  - `sweep_req` in any state: all queued entries are discarded. A push in the same cycle is also discarded.
  - Repeated updates to the same index are serialized. Each READ sees the previous WRITE because the write commits at the edge before the READ.
  - `rst` mid-operation: same as `sweep_req`, plus all registers return to reset values.

## Timing
- While `rst`=1, outputs are `tbl_we`=0, `upd_ready`=0, `busy`=1, and all other outputs 0.
- After reset, state is SWEEP with sweep index 0 and the queue empty.
- Sweep timing:
  - Entry i is written in the i-th cycle after `rst` deasserts (i from 0).
  - `busy` falls after exactly N_REG cycles.
  - A `sweep_req` sweep starts the cycle after the request and lasts N_REG cycles.
- Update latency, starting from a push at edge E0 with the FSM in IDLE and the queue empty:
  - READ in the cycle after E1.
  - WRITE in the cycle after E2.
  - Table updated at E3.
- Throughput is one update per 2 cycles back-to-back.
- All outputs are Moore: decoded from registered state, FIFO head and `ctr_q`. The only exception is `upd_ready`, which comes from the registered count.

## Structure
- Shared package `bp_pkg` holds:
  - State enum: SWEEP, IDLE, READ, WRITE.
  - Counter constants: SNT=00, WNT=01, WT=10, ST=11.
  - The reset counter value, WNT.
  - Function `bp_next_ctr(ctr, mispredict)`.
  - The BRANCH opcode constant 7'b1100011.
- One sub-module `bp_update_fifo`:
  - Synchronous FIFO, QDEPTH entries, width N_BITS+65.
  - Ports: push, pop, clear, full, empty, head.

## Test plan
- **Reset sweep.** Release `rst` → `tbl_we`=1 for 16 consecutive cycles with idx 0..15, ctr=01, valid=0. `busy`=1 throughout, then 0.
- **Single correct update.** Entry 5 holds ctr=10. Push idx=5, target=0x1000, mispredict=0 → 3 cycles later `tbl_we` with idx=5, ctr=11, valid=1, target=0x1000.
- **Mispredict chain, same index.** Entry 3 holds ctr=00. Push idx=3 with mispredict=1 twice back-to-back → writes ctr=01, then ctr=10, 2 cycles apart.
- **Full queue.** Hold the FSM busy in SWEEP and push 4 updates → `upd_ready`=0. A 5th `upd_valid` is not accepted. After the sweep, 4 writes follow in FIFO order.
- **Sweep during WRITE.** Pulse `sweep_req` in a WRITE cycle with 2 entries queued → that write commits. The sweep of 16 entries follows, and no queued update is ever written.
- **Reset mid-READ.** Assert `rst` during READ → `tbl_we`=0 during reset. A fresh sweep starts on release, and the queue is empty afterwards.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types and constants: FSM states, 2-bit counter
// encodings and the counter update rule used by the BPT write port.
package bp_pkg;

  typedef enum logic [1:0] {
    SWEEP = 2'b00,
    IDLE  = 2'b01,
    READ  = 2'b10,
    WRITE = 2'b11
  } bp_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = WNT;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Correct predictions saturate toward the current direction; a mispredict
  // moves one step toward the opposite direction.
  function automatic logic [1:0] bp_next_ctr(input logic [1:0] ctr, input logic mispredict);
    logic [1:0] nxt;
    nxt = ctr;
    if (!mispredict) begin
      case (ctr)
        SNT, WNT: nxt = SNT;
        default:  nxt = ST;
      endcase
    end else begin
      case (ctr)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        WT:      nxt = WNT;
        default: nxt = WT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpt_update_ctrl_if.sv
// Bus between the BPT write-port controller, the ID-stage update source and
// the prediction table storage.
interface bpt_update_ctrl_if #(
  parameter int unsigned N_BITS = 4
);
  logic              upd_valid;
  logic              upd_ready;
  logic [N_BITS-1:0] upd_idx;
  logic [63:0]       upd_target;
  logic              upd_mispredict;
  logic              sweep_req;
  logic [N_BITS-1:0] tbl_rd_idx;
  logic [1:0]        tbl_rd_ctr;
  logic              tbl_we;
  logic [N_BITS-1:0] tbl_wr_idx;
  logic [63:0]       tbl_wr_target;
  logic [1:0]        tbl_wr_ctr;
  logic              tbl_wr_valid;
  logic              busy;

  modport master (
    output upd_valid, upd_idx, upd_target, upd_mispredict, sweep_req, tbl_rd_ctr,
    input  upd_ready, tbl_rd_idx, tbl_we, tbl_wr_idx, tbl_wr_target, tbl_wr_ctr,
           tbl_wr_valid, busy
  );

  modport slave (
    input  upd_valid, upd_idx, upd_target, upd_mispredict, sweep_req, tbl_rd_ctr,
    output upd_ready, tbl_rd_idx, tbl_we, tbl_wr_idx, tbl_wr_target, tbl_wr_ctr,
           tbl_wr_valid, busy
  );
endinterface

// File: rtl/bp_update_fifo.sv
// Synchronous update FIFO with clear; `last` flags exactly one entry so the
// controller can chain read-modify-writes without an idle cycle.
module bp_update_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic             last,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (count_q == (PW+1)'(DEPTH));
    empty   = (count_q == '0);
    last    = (count_q == (PW+1)'(1));
    head    = mem_q[rd_ptr_q];
    do_push = push && !full && !clear;
    do_pop  = pop && !empty && !clear;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bpt_update_ctrl.sv
// Branch prediction table write-port controller: queues resolved-branch
// updates, performs counter read-modify-writes and runs the init sweep.
module bpt_update_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned N_REG  = 16,
  parameter int unsigned N_BITS = $clog2(N_REG),
  parameter int unsigned QDEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  bpt_update_ctrl_if.slave bus
);
  localparam int unsigned FW = N_BITS + 65;

  logic [FW-1:0]     push_data, head;
  logic              fifo_full, fifo_empty, fifo_last;
  logic              fifo_push, fifo_pop, fifo_clear;
  logic              upd_ready;
  logic [N_BITS-1:0] head_idx;
  logic [63:0]       head_target;
  logic              head_mis;

  bp_state_e         state_q, state_d;
  logic [N_BITS-1:0] sweep_idx_q, sweep_idx_d;
  logic [1:0]        ctr_q, ctr_d;

  assign push_data = {bus.upd_idx, bus.upd_target, bus.upd_mispredict};
  assign {head_idx, head_target, head_mis} = head;

  bp_update_fifo #(
    .WIDTH (FW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .push_data (push_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .last      (fifo_last),
    .head      (head)
  );

  always_comb begin
    upd_ready  = !fifo_full && !rst;
    fifo_push  = bus.upd_valid && upd_ready;
    fifo_clear = rst || bus.sweep_req;
    fifo_pop   = (state_q == WRITE);

    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    ctr_d       = ctr_q;
    case (state_q)
      SWEEP: begin
        if (sweep_idx_q == N_BITS'(N_REG - 1)) state_d = IDLE;
        else sweep_idx_d = sweep_idx_q + N_BITS'(1);
      end
      IDLE:  if (!fifo_empty) state_d = READ;
      READ: begin
        ctr_d   = bus.tbl_rd_ctr;
        state_d = WRITE;
      end
      // A same-cycle push keeps the queue non-empty even if this pop drains it.
      WRITE:   state_d = (!fifo_last || fifo_push) ? READ : IDLE;
      default: state_d = SWEEP;
    endcase

    if (bus.sweep_req) begin
      state_d     = SWEEP;
      sweep_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
      ctr_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      ctr_q       <= ctr_d;
    end
  end

  always_comb begin
    bus.upd_ready     = upd_ready;
    bus.busy          = rst || (state_q == SWEEP);
    bus.tbl_rd_idx    = '0;
    bus.tbl_we        = 1'b0;
    bus.tbl_wr_idx    = '0;
    bus.tbl_wr_target = '0;
    bus.tbl_wr_ctr    = '0;
    bus.tbl_wr_valid  = 1'b0;
    if (!rst) begin
      case (state_q)
        SWEEP: begin
          bus.tbl_we     = 1'b1;
          bus.tbl_wr_idx = sweep_idx_q;
          bus.tbl_wr_ctr = CTR_RESET;
        end
        READ: bus.tbl_rd_idx = head_idx;
        WRITE: begin
          bus.tbl_we        = 1'b1;
          bus.tbl_wr_idx    = head_idx;
          bus.tbl_wr_target = head_target;
          bus.tbl_wr_valid  = 1'b1;
          bus.tbl_wr_ctr    = bp_next_ctr(ctr_q, head_mis);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bpt_update_ctrl.sv
// Scoreboard bench for bpt_update_ctrl: a table model predicts every write,
// and a negedge monitor compares each table write against the queue head.
module tb_bpt_update_ctrl;
  localparam int unsigned NR = 16;
  localparam int unsigned NB = 4;

  typedef struct {
    logic [NB-1:0] idx;
    logic [63:0]   tgt;
    logic [1:0]    ctr;
    logic          valid;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpt_update_ctrl_if #(.N_BITS(NB)) bus ();

  bpt_update_ctrl #(
    .N_REG  (NR),
    .N_BITS (NB),
    .QDEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Table storage the controller writes into.
  logic [1:0]  mem_ctr [NR];
  logic        mem_valid [NR];
  logic [63:0] mem_tgt [NR];
  assign bus.tbl_rd_ctr = mem_ctr[bus.tbl_rd_idx];
  always @(posedge clk) begin
    if (bus.tbl_we === 1'b1) begin
      mem_ctr[bus.tbl_wr_idx]   <= bus.tbl_wr_ctr;
      mem_valid[bus.tbl_wr_idx] <= bus.tbl_wr_valid;
      mem_tgt[bus.tbl_wr_idx]   <= bus.tbl_wr_target;
    end
  end

  // Reference model: counter per entry plus the expected write stream.
  int  ref_ctr [NR];
  int  nxt_ok [4] = '{0, 0, 3, 3};
  int  nxt_mp [4] = '{1, 2, 1, 2};
  wr_t expq [$];
  int  wr_cyc [$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("reset_we", bus.tbl_we, 1'b0);
      check("reset_busy", bus.busy, 1'b1);
      check("reset_ready", bus.upd_ready, 1'b0);
    end
    if (bus.tbl_we !== 1'b1) begin
      check("wr_idle_zero",
            {bus.tbl_wr_idx, bus.tbl_wr_target, bus.tbl_wr_ctr, bus.tbl_wr_valid}, '0);
    end else begin
      wr_t e;
      wr_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got idx=%0d ctr=%0d expected no write (t=%0t)",
                 bus.tbl_wr_idx, bus.tbl_wr_ctr, $time);
      end else begin
        e = expq.pop_front();
        check("wr_idx", bus.tbl_wr_idx, e.idx);
        check("wr_ctr", bus.tbl_wr_ctr, e.ctr);
        check("wr_valid", bus.tbl_wr_valid, e.valid);
        check("wr_target", bus.tbl_wr_target, e.tgt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_expect(input int keep);
    wr_t e;
    while (expq.size() > keep) void'(expq.pop_back());
    for (int unsigned i = 0; i < NR; i++) begin
      e.idx = NB'(i); e.tgt = '0; e.ctr = 2'b01; e.valid = 1'b0;
      expq.push_back(e);
      ref_ctr[i] = 1;
    end
  endtask

  task automatic push_one(input logic [NB-1:0] idx, input logic [63:0] tgt,
                          input logic mis, output bit acc);
    wr_t e;
    bus.upd_valid = 1'b1; bus.upd_idx = idx; bus.upd_target = tgt; bus.upd_mispredict = mis;
    @(negedge clk);
    acc = (bus.upd_ready === 1'b1);
    tick();
    bus.upd_valid = 1'b0;
    if (acc) begin
      ref_ctr[idx] = mis ? nxt_mp[ref_ctr[idx]] : nxt_ok[ref_ctr[idx]];
      e.idx = idx; e.tgt = tgt; e.ctr = 2'(ref_ctr[idx]); e.valid = 1'b1;
      expq.push_back(e);
    end
  endtask

  task automatic pulse_sweep(input int keep);
    bus.sweep_req = 1'b1;
    sweep_expect(keep);
    tick();
    bus.sweep_req = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (expq.size() != 0 && n < 300) begin tick(); n++; end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending writes expected 0", nm, expq.size());
      expq.delete();
    end
    repeat (4) tick();
  endtask

  initial begin
    bit acc;
    int n0;
    bus.upd_valid = 1'b0; bus.upd_idx = '0; bus.upd_target = '0;
    bus.upd_mispredict = 1'b0; bus.sweep_req = 1'b0;
    for (int i = 0; i < NR; i++) begin
      mem_ctr[i] = '0; mem_valid[i] = 1'b0; mem_tgt[i] = '0; ref_ctr[i] = 0;
    end

    // Reset sweep
    repeat (3) tick();
    rst = 1'b0;
    sweep_expect(0);
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      check("sweep_busy", bus.busy, 1'b1);
      check("sweep_we", bus.tbl_we, 1'b1);
    end
    @(negedge clk);
    check("sweep_busy_fall", bus.busy, 1'b0);
    check("sweep_we_fall", bus.tbl_we, 1'b0);
    check("ready_after_reset", bus.upd_ready, 1'b1);
    drain("reset_sweep");

    // Single correct update with latency
    push_one(4'd5, 64'h0, 1'b1, acc);
    drain("prep5");
    push_one(4'd5, 64'h1000, 1'b0, acc);
    check("single_acc", acc, 1'b1);
    @(negedge clk);
    check("lat_idle_we", bus.tbl_we, 1'b0);
    @(negedge clk);
    check("lat_read_we", bus.tbl_we, 1'b0);
    check("lat_read_idx", bus.tbl_rd_idx, 4'd5);
    @(negedge clk);
    check("lat_write_we", bus.tbl_we, 1'b1);
    drain("single");

    // Mispredict chain on the same index
    push_one(4'd3, 64'h33, 1'b0, acc);
    drain("prep3");
    n0 = wr_cyc.size();
    push_one(4'd3, 64'h300, 1'b1, acc);
    push_one(4'd3, 64'h304, 1'b1, acc);
    drain("chain");
    check("chain_writes", wr_cyc.size() - n0, 2);
    if (wr_cyc.size() >= n0 + 2) check("chain_spacing", wr_cyc[n0+1] - wr_cyc[n0], 2);

    // Full queue while sweeping
    pulse_sweep(0);
    for (int i = 0; i < 4; i++) begin
      push_one(NB'($urandom_range(0, NR-1)), {$urandom, $urandom}, 1'($urandom), acc);
      check("full_push_acc", acc, 1'b1);
    end
    @(negedge clk);
    check("full_ready", bus.upd_ready, 1'b0);
    #1;
    push_one(4'd9, 64'hdead, 1'b1, acc);
    check("full_fifth_rejected", acc, 1'b0);
    drain("full");

    // Sweep during WRITE with a second entry still queued
    push_one(4'd7, 64'h700, 1'b1, acc);
    push_one(4'd8, 64'h800, 1'b1, acc);
    tick();
    check("sweep_in_write_we", bus.tbl_we, 1'b1);
    pulse_sweep(1);
    drain("sweep_in_write");
    repeat (10) tick();

    // Reset during READ
    push_one(4'd11, 64'hb00, 1'b0, acc);
    tick();
    check("reset_read_idx", bus.tbl_rd_idx, 4'd11);
    rst = 1'b1;
    expq.delete();
    repeat (2) tick();
    rst = 1'b0;
    sweep_expect(0);
    drain("reset_read");
    repeat (10) tick();
    check("reset_read_ready", bus.upd_ready, 1'b1);

    // Randomized updates
    for (int i = 0; i < 80; i++) begin
      push_one(NB'($urandom_range(0, NR-1)), {$urandom, $urandom}, 1'($urandom), acc);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain("random");
    check("random_no_pending", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
